// File: rtl/instr_feeder_if.sv
// Sequencer-side bundle: program load port, start/length control, processor
// DIN/Run/Done handshake and status flags.
interface instr_feeder_if #(
  parameter int DW = 16,
  parameter int AW = 5
);
  logic          Load;
  logic [AW-1:0] LoadAddr;
  logic [DW-1:0] LoadData;
  logic [AW:0]   Length;
  logic          Start;
  logic          Done;
  logic [DW-1:0] DIN;
  logic          Run;
  logic          Busy;
  logic          Halted;
  logic          Error;
  logic [AW:0]   PC;

  modport master (
    input  Load, LoadAddr, LoadData, Length, Start, Done,
    output DIN, Run, Busy, Halted, Error, PC
  );

  modport slave (
    output Load, LoadAddr, LoadData, Length, Start, Done,
    input  DIN, Run, Busy, Halted, Error, PC
  );
endinterface

// File: rtl/instr_feeder.sv
// Program sequencer feeding one instruction (plus immediate for mvi) at a time to proc.
// States: IDLE | ISSUE (Run pulse) | IMM (immediate word) | WAIT (for Done) | HALT | ERR
module instr_feeder #(
  parameter int          DW      = 16,
  parameter int          AW      = 5,
  parameter logic [2:0]  MVI_OP  = 3'b001,
  parameter int          TIMEOUT = 64
) (
  input logic             Clock,
  input logic             Reset,
  instr_feeder_if.master  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_IMM,
    S_WAIT,
    S_HALT,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW:0]   pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          halted_q, halted_d;
  logic          error_q, error_d;

  logic [DW-1:0] mem_q [2**AW];

  logic [AW-1:0] cur_addr, prev_addr;
  logic [DW-1:0] cur_word, prev_word;
  logic [AW:0]   pc_inc;
  logic          ctl_idle, pc_at_end, cur_is_mvi;
  logic [DW-1:0] din;
  logic          run;

  assign cur_addr   = pc_q[AW-1:0];
  assign prev_addr  = cur_addr - AW'(1);
  assign cur_word   = mem_q[cur_addr];
  assign prev_word  = mem_q[prev_addr];
  assign pc_inc     = pc_q + (AW+1)'(1);
  assign pc_at_end  = (pc_q == len_q);
  assign cur_is_mvi = (cur_word[DW-1 -: 3] == MVI_OP);
  assign ctl_idle   = (state_q == S_IDLE) || (state_q == S_HALT) || (state_q == S_ERR);

  // Program memory is deliberately left out of reset so a program survives it.
  always_ff @(posedge Clock) begin
    if (bus.Load && ctl_idle) mem_q[bus.LoadAddr] <= bus.LoadData;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_HALT, S_ERR: begin
        if (bus.Start) begin
          len_d   = bus.Length;
          pc_d    = '0;
          cnt_d   = '0;
          state_d = (bus.Length == '0) ? S_HALT : S_ISSUE;
        end
      end
      S_ISSUE: begin
        pc_d    = pc_inc;
        cnt_d   = '0;
        state_d = cur_is_mvi ? S_IMM : S_WAIT;
      end
      S_IMM: begin
        if (pc_at_end) begin
          state_d = S_ERR;
        end else begin
          pc_d = pc_inc;
          if (bus.Done) state_d = (pc_inc == len_q) ? S_HALT : S_ISSUE;
          else          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        // Done beats a timeout landing in the same cycle.
        if (bus.Done)                         state_d = pc_at_end ? S_HALT : S_ISSUE;
        else if (cnt_q == CW'(TIMEOUT - 2))   state_d = S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d   = (state_d == S_ISSUE) || (state_d == S_IMM) || (state_d == S_WAIT);
    halted_d = (state_d == S_HALT);
    error_d  = (state_d == S_ERR);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      error_q  <= error_d;
    end
  end

  // WAIT re-presents the word just issued; memory cannot change while busy.
  always_comb begin
    din = '0;
    run = 1'b0;
    case (state_q)
      S_ISSUE: begin
        din = cur_word;
        run = 1'b1;
      end
      S_IMM:   if (!pc_at_end) din = cur_word;
      S_WAIT:  din = prev_word;
      default: ;
    endcase
  end

  assign bus.DIN    = din;
  assign bus.Run    = run;
  assign bus.Busy   = busy_q;
  assign bus.Halted = halted_q;
  assign bus.Error  = error_q;
  assign bus.PC     = pc_q;

endmodule

// File: tb/tb_instr_feeder.sv
// Self-checking bench for instr_feeder: directed scenarios plus random programs
// checked against a transaction-level model of the issue sequence and timing.
module tb_instr_feeder;
  localparam int         DW      = 16;
  localparam int         AW      = 5;
  localparam int         TIMEOUT = 64;
  localparam logic [2:0] MVI     = 3'b001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] model_mem [32];

  always #5 clk = ~clk;

  instr_feeder_if #(.DW(DW), .AW(AW)) bus ();

  instr_feeder #(.DW(DW), .AW(AW), .MVI_OP(MVI), .TIMEOUT(TIMEOUT)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.Load = 1'b0; bus.LoadAddr = '0; bus.LoadData = '0;
    bus.Length = '0; bus.Start = 1'b0; bus.Done = 1'b0;
  endtask

  task automatic load_word(input int a, input logic [15:0] w);
    @(negedge clk);
    bus.Load = 1'b1; bus.LoadAddr = 5'(a); bus.LoadData = w;
    model_mem[a] = w;
    @(negedge clk);
    bus.Load = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    logic [2:0] op;
    op = 3'($urandom_range(0, 7));
    if (op == MVI) op = 3'b000;
    if ($urandom_range(0, 3) == 0) op = MVI;
    return {op, 13'($urandom)};
  endfunction

  // kfix: >0 fixed Done delay after Run, 0 random 1..4, -1 Done never arrives.
  task automatic run_program(input string name, input int len, input int kfix, input bit junk_load);
    logic [15:0] ew[$];
    int eimm[$];
    int epc[$];
    int a, idx, next_run_c, done_c, imm_c, imm_val, end_c, end_pc, k;
    bit end_err, end_known, prev_run, finished;
    a = 0;
    while (a < len) begin
      ew.push_back(model_mem[a]);
      a++;
      if (model_mem[a-1][15:13] == MVI) begin
        if (a == len) eimm.push_back(-1);
        else begin
          eimm.push_back(int'(model_mem[a]));
          a++;
        end
      end else eimm.push_back(-2);
      epc.push_back(a);
    end
    end_known = (len == 0); end_err = 1'b0; end_c = 0; end_pc = 0;
    idx = 0; next_run_c = 0; done_c = -100; imm_c = -100; imm_val = 0;
    prev_run = 1'b0; finished = 1'b0;
    @(negedge clk);
    bus.Length = 6'(len);
    bus.Start = 1'b1;
    for (int c = 0; c < 400 && !finished; c++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      bus.Load = 1'b0;
      if (c == 0 && len > 0) begin
        checks++;
        if (bus.Busy !== 1'b1 || bus.Error !== 1'b0 || bus.Halted !== 1'b0)
          begin failures++; $display("FAIL %s start_flags busy=%b err=%b halt=%b exp busy=1 err=0 halt=0", name, bus.Busy, bus.Error, bus.Halted); end
      end
      if (bus.Run === 1'b1) begin
        checks++;
        if (prev_run) begin failures++; $display("FAIL %s run_back_to_back at cycle %0d", name, c); end
        checks++;
        if (idx >= ew.size()) begin
          failures++; $display("FAIL %s unexpected_run cycle=%0d din=%h exp no run", name, c, bus.DIN);
        end else begin
          if (bus.DIN !== ew[idx]) begin failures++; $display("FAIL %s run_din idx=%0d got=%h exp=%h", name, idx, bus.DIN, ew[idx]); end
          checks++;
          if (c != next_run_c) begin failures++; $display("FAIL %s run_cycle idx=%0d got=%0d exp=%0d", name, idx, c, next_run_c); end
          k = (kfix == 0) ? int'($urandom_range(1, 4)) : kfix;
          done_c = (k < 0) ? -100 : c + k;
          next_run_c = c + k + 1;
          if (eimm[idx] >= 0) begin imm_c = c + 1; imm_val = eimm[idx]; end
          if (eimm[idx] == -1) begin
            end_known = 1'b1; end_err = 1'b1; end_c = c + 2; end_pc = epc[idx];
          end else if (k < 0) begin
            end_known = 1'b1; end_err = 1'b1; end_pc = epc[idx];
            end_c = c + TIMEOUT + ((eimm[idx] >= 0) ? 1 : 0);
          end else if (idx == ew.size() - 1) begin
            end_known = 1'b1; end_err = 1'b0; end_c = c + k + 1; end_pc = len;
          end
          idx++;
        end
      end
      if (c == imm_c) begin
        checks++;
        if (bus.DIN !== 16'(imm_val) || bus.Run !== 1'b0)
          begin failures++; $display("FAIL %s imm_word got=%h run=%b exp=%h run=0", name, bus.DIN, bus.Run, 16'(imm_val)); end
      end
      prev_run = (bus.Run === 1'b1);
      if (bus.Halted === 1'b1 || bus.Error === 1'b1) begin
        finished = 1'b1;
        checks++;
        if (!end_known || c != end_c || bus.Error !== end_err || bus.Halted !== !end_err)
          begin failures++; $display("FAIL %s end_state cycle=%0d err=%b halt=%b exp cycle=%0d err=%b known=%b", name, c, bus.Error, bus.Halted, end_c, end_err, end_known); end
        checks++;
        if (bus.PC !== 6'(end_pc) || bus.DIN !== '0 || bus.Run !== 1'b0 || bus.Busy !== 1'b0)
          begin failures++; $display("FAIL %s end_outputs pc=%0d din=%h run=%b busy=%b exp pc=%0d din=0 run=0 busy=0", name, bus.PC, bus.DIN, bus.Run, bus.Busy, end_pc); end
      end
      bus.Done = (c == done_c);
      if (junk_load && c == 1) begin
        bus.Load = 1'b1; bus.LoadAddr = '0; bus.LoadData = ~model_mem[0];
      end
    end
    if (!finished) begin
      checks++; failures++;
      $display("FAIL %s no_end got neither Halted nor Error within budget", name);
    end
    bus.Done = 1'b0;
    bus.Load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.DIN !== '0 || bus.Run !== 1'b0 || bus.Busy !== 1'b0)
      begin failures++; $display("FAIL reset_bus din=%h run=%b busy=%b exp 0", bus.DIN, bus.Run, bus.Busy); end
    checks++;
    if (bus.Halted !== 1'b0 || bus.Error !== 1'b0 || bus.PC !== '0)
      begin failures++; $display("FAIL reset_flags halt=%b err=%b pc=%0d exp 0", bus.Halted, bus.Error, bus.PC); end
    rst = 1'b0;
  endtask

  task automatic test_reset_midrun();
    load_word(0, 16'h0040);
    load_word(1, 16'h0041);
    @(negedge clk);
    bus.Length = 6'd2; bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    checks++;
    if (bus.Run !== 1'b1) begin failures++; $display("FAIL midrun_run_before got=%b exp=1", bus.Run); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.Run !== 1'b0 || bus.Busy !== 1'b0 || bus.PC !== '0 || bus.DIN !== '0)
      begin failures++; $display("FAIL midrun_reset run=%b busy=%b pc=%0d din=%h exp all 0", bus.Run, bus.Busy, bus.PC, bus.DIN); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_example_program();
    load_word(0, 16'h0040);
    load_word(1, 16'h2000);
    load_word(2, 16'h1234);
    run_program("example_done_in_imm", 3, 1, 1'b0);
    run_program("example_done_late", 3, 3, 1'b0);
  endtask

  task automatic test_missing_imm();
    load_word(0, 16'h2000);
    run_program("missing_imm", 1, 1, 1'b0);
  endtask

  task automatic test_timeout();
    load_word(0, 16'h0040);
    load_word(1, 16'h0041);
    run_program("timeout", 2, -1, 1'b0);
    run_program("restart_after_error", 2, 1, 1'b0);
  endtask

  task automatic test_zero_length();
    run_program("zero_length", 0, 1, 1'b0);
  endtask

  task automatic test_load_during_busy();
    load_word(0, 16'h0011);
    load_word(1, 16'h0022);
    run_program("load_while_busy", 2, 1, 1'b1);
    run_program("readback_after_busy_load", 2, 2, 1'b0);
  endtask

  task automatic test_random();
    int len, kfix;
    for (int i = 0; i < 10; i++) begin
      for (int a = 0; a < 32; a++) load_word(a, rand_word());
      len = (i == 3) ? 32 : int'($urandom_range(0, 12));
      kfix = (i == 7) ? -1 : 0;
      run_program($sformatf("random_%0d", i), len, kfix, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_midrun();
    test_example_program();
    test_missing_imm();
    test_timeout();
    test_zero_length();
    test_load_during_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Program sequencer upstream of the simple processor (`proc`). It drives the processor's DIN and Run inputs and consumes its Done output.
- Holds a small loadable program memory and issues one instruction at a time, waiting for Done before issuing the next.
- For move-immediate, it supplies the immediate word as well. It replaces manual switch entry of instructions, so a program runs unattended at board clock.

Parameters:
- DW, 16, instruction/data word width (matches the processor's DIN).
- AW, 5, program address width; memory depth is 2**AW words.
- MVI_OP, 3'b001, opcode value (DIN[DW-1:DW-3]) that denotes move-immediate.
- TIMEOUT, 64, maximum cycles to wait for Done before flagging an error.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous active-high reset.
- Load  in  1  write LoadData to program memory at LoadAddr (honoured only in IDLE/HALT/ERR).
- LoadAddr  in  AW  program memory write address.
- LoadData  in  DW  program word to write.
- Length  in  AW+1  number of program words to execute (0..2**AW). Sampled on Start.
- Start  in  1  single-cycle pulse; begins execution at address 0.
- Done  in  1  processor instruction-complete strobe.
- DIN  out  DW  word presented to the processor.
- Run  out  1  processor Run input; high for exactly one cycle per instruction.
- Busy  out  1  high in ISSUE/IMM/WAIT.
- Halted  out  1  high in HALT.
- Error  out  1  high in ERR.
- PC  out  AW+1  address of the next word to be presented.

Behaviour:
- Reset (async, any state): state=IDLE; PC=0; DIN=0; Run=0; Busy=0; Halted=0; Error=0; latched length=0; timeout counter=0. Memory contents are not cleared.
- Memory: synchronous write on Load. Reads are combinational from PC. A Load in ISSUE/IMM/WAIT is ignored.
- IDLE, HALT or ERR with Start=1: latch Length, PC<=0, clear timeout counter.
  - Latched length 0: go to HALT.
  - Otherwise: go to ISSUE.
  - Start has priority over Load in the same cycle; the write still occurs.
- ISSUE (1 cycle): DIN=mem[PC], Run=1, PC<=PC+1, timeout counter cleared.
  - If DIN[DW-1:DW-3]==MVI_OP: go to IMM.
  - Otherwise: go to WAIT.
  - Done is ignored in ISSUE.
- IMM (1 cycle): Run=0.
  - If PC==latched length (immediate missing): go to ERR. DIN=0. PC is not incremented.
  - Otherwise: DIN=mem[PC], PC<=PC+1.
  - If Done=1 in this cycle, go to NEXT-decision (see WAIT). Otherwise go to WAIT.
- WAIT: Run=0; DIN holds the last presented word; the timeout counter increments each cycle.
  - On Done=1: if PC==latched length, go to HALT; otherwise go to ISSUE. This is the NEXT-decision.
  - If the counter reaches TIMEOUT-1 with Done=0: go to ERR.
  - Done and timeout in the same cycle: Done wins.
- HALT: Halted=1, Run=0, DIN=0. Stays until Start or Reset.
- ERR: Error=1, Run=0, DIN=0, PC frozen for debug. Stays until Start or Reset.
- Timing:
  - Minimum issue spacing is 2 cycles for plain instructions (ISSUE, WAIT with Done in its first cycle).
  - Minimum spacing is 2 cycles for mvi when Done arrives in the IMM cycle.
  - Run is never high in two consecutive cycles.
- All outputs are registered except DIN and Run, which are decoded from state and PC (glitch-free with respect to Clock).
- Reset mid-program: immediate return to IDLE. Run drops asynchronously.

Test Plan:
- Reset during WAIT with Run pulse pending -> Run=0, Busy=0, PC=0, state IDLE within the same cycle as Reset assertion.
- Load mem[0]=16'h0040 (mv), mem[1]=16'h2000 (mvi), mem[2]=16'h1234; Length=3; Start; Done one cycle after each Run -> DIN sequence 0040 (Run=1), 2000 (Run=1), then 1234 (Run=0). Halted=1, PC=3.
- Same program with Done asserted in the IMM cycle -> next state HALT directly. Total 4 cycles from first Run to Halted.
- Length=1, mem[0]=16'h2000 (mvi, immediate missing) -> one Run pulse, then Error=1, PC=1, DIN=0.
- Length=2 of plain instructions, Done never asserted -> Error=1 exactly TIMEOUT cycles after the first Run. A subsequent Start clears Error and reissues mem[0].
- Length=0 Start -> Halted=1 the next cycle, Run never asserted. Load during Busy -> memory unchanged (readback after HALT via rerun).
